i2c_pwm_slave: RTL and testbench
================================

// Module: i2c_pwm_slave
// PURPOSE
//  I2C slave register block upstream of PWM_INTERFACE; owns the 8-bit duty-cycle register feeding PWM_DCycle.
//  Oversamples SCL/SDA on CLK_IN (no SCL-domain logic); supports write, read, repeated START, auto-increment.
//  Register map: 0x00 DUTY (R/W, drives PWM_DCycle), 0x01 ID (RO, = DEV_ID). Pointer uses bit 0 only.
// PARAMETERS
//  SLAVE_ADDR   7'h42   7-bit I2C address this slave answers
//  DEV_ID       8'hA5   value returned when reading register 0x01
//  SYNC_STAGES  2       flip-flop stages on SCL_IN/SDA_IN before edge detection (>=2)
// PORTS
//  CLK_IN      in   1  system clock, must be >= 16x SCL frequency
//  RST_IN      in   1  asynchronous, active-high reset
//  SCL_IN      in   1  I2C clock from pad (asynchronous)
//  SDA_IN      in   1  I2C data from pad (asynchronous)
//  SDA_OE      out  1  1 = pull SDA low (open-drain); 0 = release
//  PWM_DCycle  out  8  duty-cycle register, to PWM_INTERFACE
//  BUSY        out  1  1 while addressed (ADDR matched until STOP/mismatch)
// BEHAVIOUR
//  Reset (async, RST_IN=1): SDA_OE=0, PWM_DCycle=8'h00, BUSY=0, pointer=0, FSM=IDLE. Mid-transfer reset aborts; no partial write.
//  Sampling: SCL/SDA through SYNC_STAGES FFs; edges from last two synced samples. 2-3 CLK_IN latency pad->event.
//  START = SDA fall while SCL high; STOP = SDA rise while SCL high. START from any state -> ADDR (repeated START).
//  STOP from any state -> IDLE, SDA_OE=0, BUSY=0. START/STOP take priority over a coincident SCL edge.
//  Data bits sampled on SCL rise, MSB first; SDA_OE changes only on SCL fall (never while SCL high).
//  FSM: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
//   IDLE: wait START.  ADDR: shift 8 bits; addr==SLAVE_ADDR -> ADDR_ACK, else -> IGNORE (SDA_OE stays 0).
//   ADDR_ACK: SDA_OE=1 for 9th clock; BUSY=1; then R/W=0 -> PTR, R/W=1 -> RDATA (load reg[pointer]).
//   PTR: 8 bits; pointer<=byte[0]; ACK -> PTR_ACK -> WDATA.
//   WDATA: 8 bits; commit on 8th SCL rise: pointer 0 -> PWM_DCycle<=byte; pointer 1 -> discarded (still ACKed);
//          pointer<=~pointer (wrap 1->0); ACK -> WDATA_ACK -> WDATA.
//   RDATA: drive SDA_OE=~bit on each SCL fall; after 8 bits release -> RDATA_ACK, sample master ACK on SCL rise:
//          ACK (SDA=0) -> pointer<=~pointer, reload, RDATA; NACK -> IGNORE.
//   IGNORE: SDA_OE=0; leave only via START or STOP.
//  PWM_DCycle updates exactly once per written byte, glitch-free, registered; holds value across transactions.
//  Bit counter 3 bits, shift register 8 bits; counter clears on START and each ACK phase end.
//  Read data for reg 0 reflects PWM_DCycle value at the moment RDATA is entered.
// STRUCTURE
//  Package i2c_pwm_pkg: FSM state enum, REG_DUTY=1'b0, REG_ID=1'b1 constants.
//  Sub-module i2c_sync_edge (x2, SCL and SDA): SYNC_STAGES synchronizer, outputs level, rise, fall pulses.
//  Top: START/STOP detect, FSM, bit counter, shift register, pointer, DUTY register, SDA_OE register.
// TESTING
//  1 Write: START, 0x84(addr 0x42,W), 0x00, 0x80, STOP -> three ACKs (SDA_OE=1 in 9th clocks), PWM_DCycle=0x80.
//  2 Auto-inc read: write ptr 0x00, rSTART, 0x85, read 2 bytes ACK then NACK -> 0x80, 0xA5; SDA_OE=0 after NACK.
//  3 Wrong address: START, 0x90, 0x00, 0xFF, STOP -> SDA_OE never 1, PWM_DCycle unchanged, BUSY=0.
//  4 Write to ID: ptr 0x01, data 0x33, then data 0x44 -> both ACKed; ID read still 0xA5; pointer wraps, DUTY=0x44.
//  5 Abort: STOP after 4 data bits of a DUTY write -> PWM_DCycle unchanged, FSM IDLE; next full write succeeds.
//  6 Async RST_IN pulse mid-RDATA while SDA_OE=1 -> SDA_OE=0 and PWM_DCycle=0x00 immediately, without CLK_IN edge.

Source files
------------

// File: rtl/i2c_pwm_pkg.sv
// Shared constants for the I2C PWM slave register block.
// Holds the FSM state encodings, the register pointer values and the
// register read-back mux used by the top level.
package i2c_pwm_pkg;

  // FSM state encodings
  localparam logic [3:0] StIdle     = 4'd0;
  localparam logic [3:0] StAddr     = 4'd1;
  localparam logic [3:0] StAddrAck  = 4'd2;
  localparam logic [3:0] StPtr      = 4'd3;
  localparam logic [3:0] StPtrAck   = 4'd4;
  localparam logic [3:0] StWdata    = 4'd5;
  localparam logic [3:0] StWdataAck = 4'd6;
  localparam logic [3:0] StRdata    = 4'd7;
  localparam logic [3:0] StRdataAck = 4'd8;
  localparam logic [3:0] StIgnore   = 4'd9;

  // Register pointer values (pointer is a single bit)
  localparam logic REG_DUTY = 1'b0;
  localparam logic REG_ID   = 1'b1;

  // Read-back value of the register selected by ptr
  function automatic logic [7:0] reg_read(input logic ptr, input logic [7:0] duty,
                                          input logic [7:0] id);
    return (ptr == REG_ID) ? id : duty;
  endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous I2C pad input.
// Ports:
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   d_i     asynchronous pad input
//   level_o synchronized level
//   rise_o  one-cycle pulse on a synchronized rising edge
//   fall_o  one-cycle pulse on a synchronized falling edge
module i2c_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the idle-bus level (high) so releasing reset creates no edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/i2c_pwm_slave.sv
// I2C slave register block owning the PWM duty-cycle register.
// SCL/SDA are oversampled on CLK_IN; supports write, read, repeated START
// and pointer auto-increment. Registers: 0x00 DUTY (R/W), 0x01 ID (RO).
// Ports:
//   CLK_IN     system clock (>= 16x SCL)
//   RST_IN     asynchronous active-high reset
//   SCL_IN     I2C clock from pad
//   SDA_IN     I2C data from pad
//   SDA_OE     1 = pull SDA low
//   PWM_DCycle duty-cycle register
//   BUSY       high while this slave is addressed
module i2c_pwm_slave
  import i2c_pwm_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR  = 7'h42,
  parameter logic [7:0]  DEV_ID      = 8'hA5,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       CLK_IN,
  input  logic       RST_IN,
  input  logic       SCL_IN,
  input  logic       SDA_IN,
  output logic       SDA_OE,
  output logic [7:0] PWM_DCycle,
  output logic       BUSY
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
    .clk_i   (CLK_IN),
    .rst_i   (RST_IN),
    .d_i     (SCL_IN),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
    .clk_i   (CLK_IN),
    .rst_i   (RST_IN),
    .d_i     (SDA_IN),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  logic       start_det, stop_det;
  logic [3:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] duty_q, duty_d;
  logic       ptr_q, ptr_d;
  logic       oe_q, oe_d;
  logic       busy_q, busy_d;
  logic       load_q, load_d;
  logic [7:0] byte_in;
  logic [7:0] rd_val;

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;
  assign byte_in   = {shift_q[6:0], sda_lvl};
  assign rd_val    = reg_read(ptr_q, duty_q, DEV_ID);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    duty_d  = duty_q;
    ptr_d   = ptr_q;
    oe_d    = oe_q;
    busy_d  = busy_q;
    load_d  = load_q;
    if (stop_det) begin
      state_d = StIdle;
      oe_d    = 1'b0;
      busy_d  = 1'b0;
      load_d  = 1'b0;
    end else if (start_det) begin
      state_d = StAddr;
      cnt_d   = 3'd0;
      load_d  = 1'b0;
    end else begin
      case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == SLAVE_ADDR) begin
                state_d = StAddrAck;
                busy_d  = 1'b1;
              end else begin
                state_d = StIgnore;
                busy_d  = 1'b0;
              end
            end
          end
        end
        // ACK phases: the first SCL fall asserts SDA_OE, the second ends the phase
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!oe_q) begin
              oe_d = 1'b1;
            end else begin
              oe_d  = 1'b0;
              cnt_d = 3'd0;
              if (state_q == StAddrAck && shift_q[0]) begin
                // Read: latch register and present its MSB on the same fall
                state_d = StRdata;
                shift_d = {rd_val[6:0], 1'b0};
                oe_d    = ~rd_val[7];
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StPtr: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ptr_d   = byte_in[0];
              state_d = StPtrAck;
            end
          end
        end
        StWdata: begin
          if (scl_rise) begin
            shift_d = byte_in;
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (ptr_q == REG_DUTY) begin
                duty_d = byte_in;
              end
              ptr_d   = ~ptr_q;
              state_d = StWdataAck;
            end
          end
        end
        // shift_q[7] always holds the next bit to drive
        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              state_d = StRdataAck;
              cnt_d   = 3'd0;
            end
          end else if (scl_fall) begin
            if (load_q) begin
              shift_d = {rd_val[6:0], 1'b0};
              oe_d    = ~rd_val[7];
              load_d  = 1'b0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              oe_d    = ~shift_q[7];
            end
          end
        end
        StRdataAck: begin
          if (scl_fall) begin
            oe_d = 1'b0;
          end else if (scl_rise) begin
            cnt_d = 3'd0;
            if (!sda_lvl) begin
              ptr_d   = ~ptr_q;
              load_d  = 1'b1;
              state_d = StRdata;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        StIgnore: oe_d = 1'b0;
        default: begin
          state_d = StIdle;
          oe_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state_q <= StIdle;
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      duty_q  <= 8'h00;
      ptr_q   <= REG_DUTY;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      duty_q  <= duty_d;
      ptr_q   <= ptr_d;
      oe_q    <= oe_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
    end
  end

  assign SDA_OE     = oe_q;
  assign PWM_DCycle = duty_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_i2c_pwm_slave.sv
// Directed bench for i2c_pwm_slave: an I2C master model drives SCL/SDA
// (open-drain bus with the slave's SDA_OE) and checks ACKs, read data,
// the duty register, BUSY and asynchronous reset.
module tb_i2c_pwm_slave;

  localparam int HalfScl = 10;  // CLK_IN cycles per SCL half period

  logic       clk;
  logic       rst;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] pwm;
  logic       busy;

  int tests_run    = 0;
  int tests_failed = 0;
  int oe_count     = 0;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_pwm_slave #(
    .SLAVE_ADDR  (7'h42),
    .DEV_ID      (8'hA5),
    .SYNC_STAGES (2)
  ) dut (
    .CLK_IN     (clk),
    .RST_IN     (rst),
    .SCL_IN     (scl_m),
    .SDA_IN     (sda_bus),
    .SDA_OE     (sda_oe),
    .PWM_DCycle (pwm),
    .BUSY       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (sda_oe === 1'b1) oe_count <= oe_count + 1;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL clock: data set mid-low, SDA_OE sampled mid-high
  task automatic clock_bit(input logic b, output logic oe_hi);
    wait_clk(HalfScl / 2);
    sda_m = b;
    wait_clk(HalfScl / 2);
    scl_m = 1'b1;
    wait_clk(HalfScl / 2);
    oe_hi = sda_oe;
    wait_clk(HalfScl / 2);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    wait_clk(HalfScl / 2);
    sda_m = 1'b1;
    wait_clk(HalfScl / 2);
    scl_m = 1'b1;
    wait_clk(HalfScl);
    sda_m = 1'b0;
    wait_clk(HalfScl);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clk(HalfScl / 2);
    sda_m = 1'b0;
    wait_clk(HalfScl / 2);
    scl_m = 1'b1;
    wait_clk(HalfScl);
    sda_m = 1'b1;
    wait_clk(HalfScl);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic oe;
    for (int i = 7; i >= 0; i--) clock_bit(d[i], oe);
    clock_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] data);
    logic oe;
    data = 8'h00;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, oe);
      data = {data[6:0], ~oe};
    end
    clock_bit(~master_ack, oe);
  endtask

  initial begin
    logic       ack;
    logic       oe;
    logic [7:0] rd;
    int         oe_base;

    rst   = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(4);
    check_eq("reset_sda_oe", {7'd0, sda_oe}, 8'h00);
    check_eq("reset_pwm", pwm, 8'h00);
    check_eq("reset_busy", {7'd0, busy}, 8'h00);

    // 1: write 0x80 to DUTY
    i2c_start();
    write_byte(8'h84, ack); check_eq("t1_addr_ack", {7'd0, ack}, 8'h01);
    check_eq("t1_busy", {7'd0, busy}, 8'h01);
    write_byte(8'h00, ack); check_eq("t1_ptr_ack", {7'd0, ack}, 8'h01);
    write_byte(8'h80, ack); check_eq("t1_data_ack", {7'd0, ack}, 8'h01);
    i2c_stop();
    check_eq("t1_pwm", pwm, 8'h80);
    check_eq("t1_busy_after_stop", {7'd0, busy}, 8'h00);

    // 2: auto-increment read through repeated START
    i2c_start();
    write_byte(8'h84, ack); check_eq("t2_addr_ack", {7'd0, ack}, 8'h01);
    write_byte(8'h00, ack); check_eq("t2_ptr_ack", {7'd0, ack}, 8'h01);
    i2c_start();
    write_byte(8'h85, ack); check_eq("t2_raddr_ack", {7'd0, ack}, 8'h01);
    read_byte(1'b1, rd); check_eq("t2_read_duty", rd, 8'h80);
    read_byte(1'b0, rd); check_eq("t2_read_id", rd, 8'hA5);
    wait_clk(HalfScl / 2);
    check_eq("t2_oe_after_nack", {7'd0, sda_oe}, 8'h00);
    i2c_stop();

    // 3: wrong address is ignored
    oe_base = oe_count;
    i2c_start();
    write_byte(8'h90, ack); check_eq("t3_addr_nack", {7'd0, ack}, 8'h00);
    check_eq("t3_busy_during", {7'd0, busy}, 8'h00);
    write_byte(8'h00, ack);
    write_byte(8'hFF, ack);
    i2c_stop();
    check_eq("t3_oe_never", (oe_count == oe_base) ? 8'h01 : 8'h00, 8'h01);
    check_eq("t3_pwm", pwm, 8'h80);

    // 4: writes to ID are ACKed but dropped; pointer wraps to DUTY
    i2c_start();
    write_byte(8'h84, ack); check_eq("t4_addr_ack", {7'd0, ack}, 8'h01);
    write_byte(8'h01, ack); check_eq("t4_ptr_ack", {7'd0, ack}, 8'h01);
    write_byte(8'h33, ack); check_eq("t4_id_data_ack", {7'd0, ack}, 8'h01);
    check_eq("t4_pwm_after_id", pwm, 8'h80);
    write_byte(8'h44, ack); check_eq("t4_wrap_data_ack", {7'd0, ack}, 8'h01);
    i2c_stop();
    check_eq("t4_pwm", pwm, 8'h44);
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h01, ack);
    i2c_start();
    write_byte(8'h85, ack);
    read_byte(1'b0, rd); check_eq("t4_read_id", rd, 8'hA5);
    i2c_stop();

    // 5: STOP in the middle of a data byte aborts the write
    i2c_start();
    write_byte(8'h84, ack); check_eq("t5_addr_ack", {7'd0, ack}, 8'h01);
    write_byte(8'h00, ack); check_eq("t5_ptr_ack", {7'd0, ack}, 8'h01);
    clock_bit(1'b0, oe);
    clock_bit(1'b0, oe);
    clock_bit(1'b0, oe);
    clock_bit(1'b1, oe);
    i2c_stop();
    check_eq("t5_pwm_unchanged", pwm, 8'h44);
    check_eq("t5_busy", {7'd0, busy}, 8'h00);
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h00, ack);
    write_byte(8'h5A, ack); check_eq("t5_retry_ack", {7'd0, ack}, 8'h01);
    i2c_stop();
    check_eq("t5_pwm_retry", pwm, 8'h5A);

    // 6: asynchronous reset while the slave drives a read bit low
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h00, ack);
    i2c_start();
    write_byte(8'h85, ack);
    wait_clk(5);
    check_eq("t6_oe_before_rst", {7'd0, sda_oe}, 8'h01);
    check_eq("t6_pwm_before_rst", pwm, 8'h5A);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_oe_async", {7'd0, sda_oe}, 8'h00);
    check_eq("t6_pwm_async", pwm, 8'h00);
    check_eq("t6_busy_async", {7'd0, busy}, 8'h00);
    wait_clk(2);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(HalfScl);
    i2c_start();
    write_byte(8'h84, ack);
    write_byte(8'h00, ack);
    write_byte(8'h11, ack); check_eq("t6_recover_ack", {7'd0, ack}, 8'h01);
    i2c_stop();
    check_eq("t6_recover_pwm", pwm, 8'h11);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
